// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the encoder and the pipelined decoder.
// Functions take words padded to GRAY_MAX_W so one definition serves every width.
package gray_pkg;

   localparam int GRAY_MAX_W = 256;

   // Bit range owned by one decoder stage; empty stages own no bits at all
   typedef struct packed {
      int   hi;
      int   lo;
      logic empty;
   } chunk_t;

   // Binary to Gray, used by the transmit-side encoder
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Resolves bits hi..lo of a partially decoded word. Bits above hi are already
   // binary, bits below lo are left as Gray, and seed is the binary bit at hi+1
   // (zero for the top chunk so its MSB passes straight through).
   function automatic logic [GRAY_MAX_W-1:0] gray2bin_chunk(
      input logic [GRAY_MAX_W-1:0] data,
      input logic                  seed,
      input int                    hi,
      input int                    lo
   );
      logic [GRAY_MAX_W-1:0] res;
      logic                  acc;
      res = data;
      acc = seed;
      for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
         if (i <= hi && i >= lo) begin
            acc    = acc ^ data[i];
            res[i] = acc;
         end
      end
      return res;
   endfunction

   // Chunk boundaries for stage k when a width-w word is split over s stages.
   // Chunks are ceil(w/s) bits from the MSB down; trailing stages can end up
   // with nothing to resolve and are flagged empty with hi below lo.
   function automatic chunk_t chunk_bounds(input int w, input int s, input int k);
      chunk_t b;
      int     c;
      int     top;
      int     bot;
      c   = (w + s - 1) / s;
      top = w - 1 - k * c;
      bot = w - (k + 1) * c;
      if (bot < 0) begin
         bot = 0;
      end
      if (top < 0) begin
         b.hi    = -1;
         b.lo    = 0;
         b.empty = 1'b1;
      end else begin
         b.hi    = top;
         b.lo    = bot;
         b.empty = 1'b0;
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_stage.sv
// One decoder pipeline stage: a valid/data register, the XOR chain for its
// chunk and the skid-free ready equation that lets an empty stage fill even
// while everything downstream is stalled.
module gray2bin_stage
   import gray_pkg::*;
#(
   parameter int D_WIDTH  = 8,
   parameter int HI       = 7,
   parameter int LO       = 0,
   parameter bit HAS_SEED = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               up_valid,
   input  logic [D_WIDTH-1:0] up_data,
   input  logic               down_ready,
   output logic               ready,
   output logic               valid,
   output logic [D_WIDTH-1:0] data
);

   logic               seed;
   logic [D_WIDTH-1:0] resolved;
   logic               valid_q;
   logic [D_WIDTH-1:0] data_q;

   // The seed is the already-binary bit just above this chunk in the upstream word
   if (HAS_SEED) begin : g_seed
      assign seed = up_data[HI+1];
   end else begin : g_no_seed
      assign seed = 1'b0;
   end

   assign resolved = D_WIDTH'(gray2bin_chunk(GRAY_MAX_W'(up_data), seed, HI, LO));

   // A stage can take a new word if it is empty or its word is leaving this cycle
   assign ready = !valid_q || down_ready;

   // Valid follows upstream whenever the stage loads, so bubbles propagate too
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else if (ready) begin
         valid_q <= up_valid;
      end
   end

   // Data only moves when a real word arrives; bubbles leave the register untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (ready && up_valid) begin
         data_q <= resolved;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/gray2bin_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready flow control.
// The XOR-prefix chain is cut into STAGES chunks, one per register stage,
// MSB chunk first; the top level only chains the stages together.
module gray2bin_pipe
   import gray_pkg::*;
#(
   parameter int D_WIDTH = 8,
   parameter int STAGES  = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [D_WIDTH-1:0] in_data_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   output logic [D_WIDTH-1:0] out_data_o,
   output logic               out_valid_o,
   input  logic               out_ready_i
);

   logic [STAGES:0]    valid_chain;
   logic [D_WIDTH-1:0] data_chain [STAGES+1];

   assign valid_chain[0] = in_valid_i;
   assign data_chain[0]  = in_data_i;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam chunk_t BOUNDS = chunk_bounds(D_WIDTH, STAGES, k);

      logic stage_ready;
      logic down_ready;

      // Ready ripples back from the output; each stage keeps its own wire so
      // the chain is not one vector feeding itself
      if (k == STAGES - 1) begin : g_last
         assign down_ready = out_ready_i;
      end else begin : g_mid
         assign down_ready = g_stage[k+1].stage_ready;
      end

      gray2bin_stage #(
         .D_WIDTH  (D_WIDTH),
         .HI       (BOUNDS.hi),
         .LO       (BOUNDS.lo),
         .HAS_SEED ((k != 0) && !BOUNDS.empty)
      ) u_stage (
         .clk        (clk_i),
         .rst        (rst_i),
         .up_valid   (valid_chain[k]),
         .up_data    (data_chain[k]),
         .down_ready (down_ready),
         .ready      (stage_ready),
         .valid      (valid_chain[k+1]),
         .data       (data_chain[k+1])
      );
   end

   assign in_ready_o  = g_stage[0].stage_ready;
   assign out_valid_o = valid_chain[STAGES];
   assign out_data_o  = data_chain[STAGES];

endmodule

// File: doc/gray2bin_pipe.md
# gray2bin_pipe

Pipelined Gray-to-binary decoder, the receive-side counterpart of the team's binary-to-Gray encoder. Typical use: decoding Gray-coded pointers or counters after they cross into this clock domain, for example FIFO pointers or encoder positions. The serial XOR-prefix chain is split across `STAGES` register stages to meet timing at wide `D_WIDTH`. Full valid/ready flow control runs end to end, and every stage collapses bubbles.

## Interface
- `D_WIDTH`, 8: data width in bits; legal range is 2 or more.
- `STAGES`, 2: number of pipeline register stages; legal range is 1 ≤ `STAGES` ≤ `D_WIDTH`.
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `in_data_i` in `D_WIDTH`: Gray-coded input word.
- `in_valid_i` in 1: input word is valid.
- `in_ready_o` out 1: block accepts a word this cycle.
- `out_data_o` out `D_WIDTH`: decoded binary word.
- `out_valid_o` out 1: `out_data_o` is valid.
- `out_ready_i` in 1: downstream accepts the word this cycle.

## Operation
- Decode rule:
  - `b[D_WIDTH-1] = g[D_WIDTH-1]`
  - `b[i] = b[i+1] ^ g[i]` for i from `D_WIDTH-2` down to 0.
  - This is the exact inverse of `g = b ^ (b >> 1)`.
- Chunk size `C = ceil(D_WIDTH / STAGES)`.
- Stage k (k = 0..`STAGES-1`) resolves bits `[D_WIDTH-1-k*C : max(0, D_WIDTH-(k+1)*C)]`.
  - Its seed is the resolved binary bit directly above its chunk.
  - Stage 0 has no seed; its top bit passes straight through.
  - If `STAGES*C` exceeds `D_WIDTH`, trailing stages may own zero bits. Such stages are pure registers and pass data unchanged.
- Each stage register holds a mixed word:
  - bits above and including its chunk are binary;
  - bits below it are still Gray.
- The final stage output is fully binary.
- Each stage k owns `valid_q[k]` and `data_q[k]`. Readiness and loading:
  - `ready[k] = !valid_q[k] || ready[k+1]`.
  - `ready[STAGES] = out_ready_i`.
  - `in_ready_o = ready[0]`, a combinational path from `out_ready_i`. This path is accepted by design.
  - Stage k loads when `ready[k]` is high. It captures the upstream valid and, only when upstream is valid, the upstream data.
  - Data registers do not update on bubbles. This is a power requirement; verification checks it.
- `out_valid_o = valid_q[STAGES-1]` and `out_data_o = data_q[STAGES-1]`.
- Handshake:
  - A transfer occurs on any cycle where valid and ready are both high.
  - Once `out_valid_o` is asserted, `out_data_o` must stay stable until it is accepted.
  - `in_valid_i` may drop without a transfer; the block must not depend on upstream holding it.
- Word order is preserved. No word is dropped or duplicated under any stall pattern.

## Timing
- Reset (asynchronous, while `rst_i` is high):
  - all `valid_q` = 0 and all `data_q` = 0;
  - therefore `out_valid_o` = 0, `out_data_o` = 0, and `in_ready_o` = 1.
- Latency: a word accepted at edge n appears on `out_valid_o` after edge n+`STAGES-1`, i.e. `STAGES` cycles after acceptance.
- Throughput: one word per cycle while `out_ready_i` is held high.
- Full stall (`out_ready_i` low):
  - the pipeline fills;
  - `in_ready_o` falls in the same cycle the last empty stage is claimed;
  - capacity is exactly `STAGES` words.
- Partial bubbles: an empty stage accepts even when downstream is stalled, so gaps compress.
- Simultaneous accept and emit on a full pipeline with `out_ready_i` high: all stages advance and `in_ready_o` stays high.
- Reset asserted mid-operation: all in-flight words are discarded immediately. Outputs return to reset values without waiting for a clock edge.
- Release of `rst_i` is synchronous to the system. The first accept may occur on the first edge after release.

## Structure
- Package `gray_pkg`, shared with the encoder:
  - function `gray2bin_chunk(data, seed, hi, lo)`, which resolves bits `hi..lo` from the seed;
  - constant helper `chunk_bounds(D_WIDTH, STAGES, k)`.
- Sub-module `gray2bin_stage`, instantiated `STAGES` times in a generate loop.
  - Contains one valid/data register, the chunk XOR logic, and the ready equation.
  - Its parameters are `D_WIDTH`, `HI`, `LO`, `HAS_SEED`.
- Top level only wires the stages and maps the handshake ports.

## Test plan
1. Reset check (`D_WIDTH`=8, `STAGES`=3). Assert `rst_i` mid-stream with 3 words in flight. Required: `out_valid_o`=0 and `out_data_o`=0 asynchronously, `in_ready_o`=1, and no stale word emerges after release.
2. Known values with `out_ready_i`=1. Inputs 8'h00, 8'h01, 8'hC0, 8'h80 are back to back. Required outputs: 8'h00, 8'h01, 8'h80, 8'hFF, each exactly 3 cycles after acceptance, one per cycle.
3. Exhaustive round trip. Encode 0..255 with the binary-to-Gray encoder and feed the results in. Required: outputs equal 0..255 in order, for `STAGES` = 1, 3, and 8 (chunk of 1 bit).
4. Backpressure. Hold `out_ready_i`=0 and offer 5 words. Required: exactly 3 accepted, then `in_ready_o`=0, and `out_data_o` stable. Release `out_ready_i`: all 5 words emerge in order with no loss or duplication.
5. Random stress. Random `in_valid_i` and `out_ready_i` (50% each) for 10k words at `D_WIDTH`=13, `STAGES`=4. Required: the scoreboard matches the reference decode, and the stable-while-valid assertion never fires.
6. Bubble collapse. With the output stalled, feed words on cycles 0 and 2 only. Required: both words occupy adjacent stages and `in_ready_o` remains high for the third slot.
